// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: control codes, MIPS opcode/funct values,
// decode and issue-bundle types used by the issue stage and its decoder.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int RIDX_W = 5;
    localparam int CTRL_W = 4;
    localparam int OP_W   = 6;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [CTRL_W-1:0] ALU_EQ  = 4'b1111;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;

    localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_t;

    typedef struct packed {
        logic [CTRL_W-1:0] alu_ctrl;
        logic              imm_sel;
        logic              ext_sign;
        dest_sel_t         dest_sel;
        logic              trap;
        logic              is_branch;
        logic              branch_ne;
        logic              illegal;
    } dec_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTRL_W-1:0] ctrl;
        logic [RIDX_W-1:0] dest;
        logic              trap;
        logic              is_branch;
        logic              branch_ne;
        logic              illegal;
    } issue_t;

    function automatic logic [DATA_W-1:0] ext_imm(
        input logic [15:0] imm,
        input logic        sign
    );
        return sign ? {{(DATA_W-16){imm[15]}}, imm}
                    : {{(DATA_W-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decoder producing ALU control fields.
// Ports: instr (32-bit instruction word) -> dec (decoded control bundle).
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    always_comb begin
        dec          = '0;
        dec.alu_ctrl = ALU_ADD;
        dec.dest_sel = DEST_NONE;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                dec.dest_sel = DEST_RD;
                case (funct)
                    FN_ADD:  begin dec.alu_ctrl = ALU_ADD; dec.trap = 1'b1; end
                    FN_ADDU: dec.alu_ctrl = ALU_ADD;
                    FN_SUB:  begin dec.alu_ctrl = ALU_SUB; dec.trap = 1'b1; end
                    FN_SUBU: dec.alu_ctrl = ALU_SUB;
                    FN_AND:  dec.alu_ctrl = ALU_AND;
                    FN_OR:   dec.alu_ctrl = ALU_OR;
                    FN_NOR:  dec.alu_ctrl = ALU_NOR;
                    FN_SLT:  dec.alu_ctrl = ALU_SLT;
                    default: begin
                        dec.illegal  = 1'b1;
                        dec.dest_sel = DEST_NONE;
                    end
                endcase
            end
            opcode == OP_ADDI: begin
                dec.imm_sel  = 1'b1;
                dec.ext_sign = 1'b1;
                dec.dest_sel = DEST_RT;
                dec.trap     = 1'b1;
            end
            opcode == OP_ADDIU: begin
                dec.imm_sel  = 1'b1;
                dec.ext_sign = 1'b1;
                dec.dest_sel = DEST_RT;
            end
            opcode == OP_SLTI: begin
                dec.alu_ctrl = ALU_SLT;
                dec.imm_sel  = 1'b1;
                dec.ext_sign = 1'b1;
                dec.dest_sel = DEST_RT;
            end
            opcode == OP_ANDI: begin
                dec.alu_ctrl = ALU_AND;
                dec.imm_sel  = 1'b1;
                dec.dest_sel = DEST_RT;
            end
            opcode == OP_ORI: begin
                dec.alu_ctrl = ALU_OR;
                dec.imm_sel  = 1'b1;
                dec.dest_sel = DEST_RT;
            end
            opcode == OP_BEQ: begin
                dec.alu_ctrl  = ALU_EQ;
                dec.is_branch = 1'b1;
            end
            opcode == OP_BNE: begin
                dec.alu_ctrl  = ALU_EQ;
                dec.is_branch = 1'b1;
                dec.branch_ne = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes register-read bundles and holds them in a
// main+skid buffer driving ALU operands/control on a valid/ready handshake.
// Ports: clk, rst, flush; in_* upstream handshake and data;
// out_valid/out_ready downstream handshake; A_in, B_in, ALU_ctrl, dest_reg,
// ovf_trap_en, is_branch, branch_ne, illegal registered bundle fields.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_rs_data,
    input  logic [XLEN-1:0]   in_rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   A_in,
    output logic [XLEN-1:0]   B_in,
    output logic [3:0]        ALU_ctrl,
    output logic [REG_AW-1:0] dest_reg,
    output logic              ovf_trap_en,
    output logic              is_branch,
    output logic              branch_ne,
    output logic              illegal
);

    dec_t   dec;
    issue_t in_b;
    issue_t main_q;
    issue_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   consume;

    alu_op_decode u_dec (
        .instr (in_instr),
        .dec   (dec)
    );

    always_comb begin
        in_b           = '0;
        in_b.a         = in_rs_data;
        in_b.b         = dec.imm_sel
                       ? ext_imm(in_instr[15:0], dec.ext_sign)
                       : in_rt_data;
        in_b.ctrl      = dec.alu_ctrl;
        in_b.trap      = dec.trap;
        in_b.is_branch = dec.is_branch;
        in_b.branch_ne = dec.branch_ne;
        in_b.illegal   = dec.illegal;
        case (dec.dest_sel)
            DEST_RD: in_b.dest = in_instr[15:11];
            DEST_RT: in_b.dest = in_instr[20:16];
            default: in_b.dest = '0;
        endcase
    end

    // in_ready is a pure function of a flop, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign consume  = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || consume) begin
            // Main frees up: refill from skid first to keep FIFO order.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_b;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_b;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign A_in        = main_q.a;
    assign B_in        = main_q.b;
    assign ALU_ctrl    = main_q.ctrl;
    assign dest_reg    = main_q.dest;
    assign ovf_trap_en = main_q.trap;
    assign is_branch   = main_q.is_branch;
    assign branch_ne   = main_q.branch_ne;
    assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: vector table through a scoreboard plus
// backpressure, flush, illegal-opcode and mid-stream reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [3:0]  ALU_ctrl;
    logic [4:0]  dest_reg;
    logic        ovf_trap_en;
    logic        is_branch;
    logic        branch_ne;
    logic        illegal;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A_in        (A_in),
        .B_in        (B_in),
        .ALU_ctrl    (ALU_ctrl),
        .dest_reg    (dest_reg),
        .ovf_trap_en (ovf_trap_en),
        .is_branch   (is_branch),
        .branch_ne   (branch_ne),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  dest;
        logic        trap;
        logic        br;
        logic        bne;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sbq[$];
    exp_t drv_exp;
    int   n_chk;
    int   n_pass;
    int   n_acc;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic exp_t out_now();
        return {A_in, B_in, ALU_ctrl, dest_reg,
                ovf_trap_en, is_branch, branch_ne, illegal};
    endfunction

    function automatic logic [31:0] r_i(input int rs, input int rt,
                                        input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_i(input int op, input int rs,
                                        input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic add(input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic [4:0] dest,
                       input logic trap, input logic br,
                       input logic bne, input logic ill);
        vec_t v;
        v.instr = instr;
        v.rs    = rs;
        v.rt    = rt;
        v.exp   = {rs, b, ctrl, dest, trap, br, bne, ill};
        vecs.push_back(v);
    endtask

    task automatic drive(input int i);
        in_valid   = 1'b1;
        in_instr   = vecs[i].instr;
        in_rs_data = vecs[i].rs;
        in_rt_data = vecs[i].rt;
        drv_exp    = vecs[i].exp;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_instr   = $urandom;
        in_rs_data = $urandom;
        in_rt_data = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable from just after one rising edge to the
    // next, so the falling edge sees exactly what the next edge will sample.
    always @(negedge clk) begin
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 96'(out_valid), 96'(0));
                end else begin
                    chk("bundle", 96'(out_now()), 96'(sbq.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(drv_exp);
                n_acc++;
            end
        end
    end

    initial begin
        int   acc0;
        exp_t held;
        n_chk = 0; n_pass = 0; n_acc = 0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drv_exp = '0;
        idle();

        add(i_i(8'h08, 1, 9, 16'hFFFE), 32'h5, 32'h1234,
            32'hFFFF_FFFE, 4'b0010, 5'd9, 1, 0, 0, 0);
        add(i_i(8'h0C, 1, 10, 16'h8001), 32'h11, 32'h22,
            32'h0000_8001, 4'b0000, 5'd10, 0, 0, 0, 0);
        add(r_i(1, 2, 11, 8'h27), 32'hF0F0_F0F0, 32'h0F0F_0000,
            32'h0F0F_0000, 4'b1100, 5'd11, 0, 0, 0, 0);
        add(i_i(8'h05, 3, 4, 16'h0010), 32'h7, 32'h8,
            32'h8, 4'b1111, 5'd0, 0, 1, 1, 0);
        add(r_i(5, 6, 12, 8'h20), 32'h7FFF_FFFF, 32'h1,
            32'h1, 4'b0010, 5'd12, 1, 0, 0, 0);
        add(r_i(5, 6, 13, 8'h21), 32'h100, 32'h200,
            32'h200, 4'b0010, 5'd13, 0, 0, 0, 0);
        add(r_i(5, 6, 14, 8'h22), 32'h300, 32'h50,
            32'h50, 4'b0110, 5'd14, 1, 0, 0, 0);
        add(r_i(5, 6, 15, 8'h23), 32'h400, 32'h60,
            32'h60, 4'b0110, 5'd15, 0, 0, 0, 0);
        add(r_i(7, 8, 16, 8'h24), 32'hDEAD_BEEF, 32'hFFFF_0000,
            32'hFFFF_0000, 4'b0000, 5'd16, 0, 0, 0, 0);
        add(r_i(7, 8, 17, 8'h25), 32'hCAFE_0000, 32'h0000_BABE,
            32'h0000_BABE, 4'b0001, 5'd17, 0, 0, 0, 0);
        add(r_i(7, 8, 18, 8'h2A), 32'h8000_0000, 32'h1,
            32'h1, 4'b0111, 5'd18, 0, 0, 0, 0);
        add(i_i(8'h09, 2, 19, 16'h8000), 32'h1000, 32'h77,
            32'hFFFF_8000, 4'b0010, 5'd19, 0, 0, 0, 0);
        add(i_i(8'h0A, 2, 20, 16'h7FFF), 32'h2000, 32'h78,
            32'h0000_7FFF, 4'b0111, 5'd20, 0, 0, 0, 0);
        add(i_i(8'h0D, 2, 21, 16'hFFFF), 32'h3000, 32'h79,
            32'h0000_FFFF, 4'b0001, 5'd21, 0, 0, 0, 0);
        add(i_i(8'h04, 2, 22, 16'hFFFF), 32'h4000, 32'h7A,
            32'h7A, 4'b1111, 5'd0, 0, 1, 0, 0);
        add(i_i(8'h3F, 1, 2, 16'h1234), 32'h5000, 32'h7B,
            32'h7B, 4'b0010, 5'd0, 0, 0, 0, 1);
        add(r_i(1, 2, 23, 8'h26), 32'h6000, 32'h7C,
            32'h7C, 4'b0010, 5'd0, 0, 0, 0, 1);
        add(r_i(1, 2, 0, 8'h20), 32'h7000, 32'h7D,
            32'h7D, 4'b0010, 5'd0, 1, 0, 0, 0);
        add(i_i(8'h02, 1, 24, 16'h0040), 32'h8000, 32'h7E,
            32'h7E, 4'b0010, 5'd0, 0, 0, 0, 1);

        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        chk("rst_data", 96'(out_now()), 96'(0));
        step();

        // Full-rate stream through the whole table.
        out_ready = 1'b1;
        acc0 = n_acc;
        drive(0);
        step();
        idle();
        @(negedge clk);
        chk("latency", 96'(out_valid), 96'(1));
        step();
        for (int i = 1; i < vecs.size(); i++) begin
            drive(i);
            step();
        end
        idle();
        repeat (3) step();
        chk("stream_acc", 96'(n_acc - acc0), 96'(vecs.size()));
        chk("stream_drain", 96'(sbq.size()), 96'(0));

        // Backpressure fills main then skid; order must survive release.
        acc0 = n_acc;
        drive(4);
        step();
        out_ready = 1'b0;
        drive(5);
        step();
        drive(6);
        @(negedge clk);
        chk("bp_ready_low", 96'(in_ready), 96'(0));
        chk("bp_hold_a", 96'(A_in), 96'(vecs[4].rs));
        held = out_now();
        step();
        @(negedge clk);
        chk("bp_stable", 96'(out_now()), 96'(held));
        chk("bp_valid", 96'(out_valid), 96'(1));
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_still_low", 96'(in_ready), 96'(0));
        step();
        @(negedge clk);
        chk("bp_ready_back", 96'(in_ready), 96'(1));
        step();
        drive(7);
        step();
        idle();
        @(negedge clk);
        chk("bp_no_gap", 96'(out_valid), 96'(1));
        step();
        @(negedge clk);
        chk("bp_empty", 96'(out_valid), 96'(0));
        chk("bp_acc", 96'(n_acc - acc0), 96'(4));
        chk("bp_drain", 96'(sbq.size()), 96'(0));

        // Flush with both entries full and a concurrent offer.
        out_ready = 1'b0;
        drive(8);
        step();
        drive(9);
        step();
        drive(10);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full", 96'(in_ready), 96'(0));
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("fl_valid", 96'(out_valid), 96'(0));
        chk("fl_ready", 96'(in_ready), 96'(1));
        step();

        // Flush must beat an accept that in_ready would allow.
        drive(11);
        step();
        drive(12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("fl_accept_valid", 96'(out_valid), 96'(0));
        out_ready = 1'b1;
        repeat (4) step();
        chk("fl_drain", 96'(sbq.size()), 96'(0));

        // Illegal bundle held, then reset mid-stream.
        out_ready = 1'b0;
        drive(15);
        step();
        idle();
        @(negedge clk);
        chk("ill_valid", 96'(out_valid), 96'(1));
        chk("ill_fields", 96'(out_now()), 96'(vecs[15].exp));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 96'(out_valid), 96'(0));
        chk("rst_mid_ready", 96'(in_ready), 96'(1));
        chk("rst_mid_data", 96'(out_now()), 96'(0));
        out_ready = 1'b1;
        repeat (3) step();
        chk("final_drain", 96'(sbq.size()), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
